// File: rtl/clk_div_sched.sv
// ---------------------------------------------------------------------------
// clk_div_sched
//
// Ratio scheduler for the programmable clock divider. Several requesters can
// ask for a new divide ratio; one is picked round-robin, its ratio is held
// while the scheduler waits, and the ratio is handed to the divider only on
// the last cycle of a divider period. Because of this, the divided clock never
// sees a shortened or lengthened period.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   W         ratio width, same as the divider div_n input
//   RESET_DIV ratio driven after reset (0 = divider passes the clock through)
//
// Ports:
//   clk        system clock, shared with the divider
//   rst_n      asynchronous active-low reset
//   req        per-requester level request
//   req_div    requested ratios, requester i on bits [i*W +: W]
//   gnt        one-cycle acknowledge, one-hot or zero
//   div_n_out  ratio currently applied to the divider
//   div_load   one-cycle strobe that comes with each div_n_out update
//   wrap       current cycle is the last cycle of a divider period
//   busy       a ratio is latched and waiting for a period boundary
// ---------------------------------------------------------------------------
module clk_div_sched #(
    parameter int           NREQ      = 4,
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_DIV = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_div,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      div_n_out,
    output logic              div_load,
    output logic              wrap,
    output logic              busy
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t          state_q;
    logic [W-1:0]    cnt_q;
    logic [W-1:0]    div_q;
    logic [W-1:0]    pendDiv_q;
    logic [SW-1:0]   rr_q;
    logic [SW-1:0]   sel_q;
    logic [NREQ-1:0] gnt_q;
    logic            load_q;

    logic [NREQ-1:0] eligible;
    logic            winFound_d;
    logic [SW-1:0]   winIdx_d;
    logic [W-1:0]    winDiv_d;
    logic [SW-1:0]   rrNext_d;
    logic [SW:0]     scanSum;
    logic [SW-1:0]   scanIdx;
    logic            wrapNow;
    logic [W-1:0]    reqDivArr [NREQ];

    // Unpack the flat ratio bus so the winner's ratio can be picked by index.
    for (genvar g = 0; g < NREQ; g++) begin : gUnpack
        assign reqDivArr[g] = req_div[g*W +: W];
    end

    // The counter mirrors the divider, so its last count marks a period boundary.
    assign wrapNow = (cnt_q == div_q);

    // Round-robin search starting at rr_q. The requester granted this cycle is
    // masked: it still holds req high while it samples its grant.
    always_comb begin
        eligible   = req & ~gnt_q;
        winFound_d = 1'b0;
        winIdx_d   = '0;
        winDiv_d   = '0;
        scanSum    = '0;
        scanIdx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scanSum = {1'b0, rr_q} + (SW+1)'(k);
            if (scanSum >= (SW+1)'(NREQ)) begin
                scanSum = scanSum - (SW+1)'(NREQ);
            end
            scanIdx = scanSum[SW-1:0];
            if (!winFound_d && eligible[scanIdx]) begin
                winFound_d = 1'b1;
                winIdx_d   = scanIdx;
                winDiv_d   = reqDivArr[scanIdx];
            end
        end
        rrNext_d = (winIdx_d == SW'(NREQ-1)) ? '0 : winIdx_d + SW'(1);
    end

    // Scheduler FSM. The period counter runs in both states. A latched ratio
    // is committed only on a wrap cycle, and the counter restarts at 0 on the
    // same edge as the divider reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= RESET_DIV;
            pendDiv_q <= '0;
            rr_q      <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            load_q    <= 1'b0;
        end else begin
            gnt_q  <= '0;
            load_q <= 1'b0;
            cnt_q  <= wrapNow ? '0 : cnt_q + W'(1);
            case (state_q)
                IDLE: begin
                    if (winFound_d) begin
                        sel_q     <= winIdx_d;
                        pendDiv_q <= winDiv_d;
                        rr_q      <= rrNext_d;
                        state_q   <= PEND;
                    end
                end
                PEND: begin
                    if (wrapNow) begin
                        div_q        <= pendDiv_q;
                        gnt_q[sel_q] <= 1'b1;
                        load_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign div_n_out = div_q;
    assign div_load  = load_q;
    assign wrap      = wrapNow;
    assign busy      = (state_q == PEND);

endmodule

// File: tb/tb_clk_div_sched.sv
// ---------------------------------------------------------------------------
// tb_clk_div_sched
//
// Testbench for clk_div_sched. It drives two instances:
//   dutA  RESET_DIV = 5. Used for the directed tests, the vector table and
//         the random traffic. Every cycle, dutA is compared with a behavioural
//         model of the period and grant rules.
//   dutB  RESET_DIV = 0. Used only for the back-to-back round-robin sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_sched;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int RESET_A = 5;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] reqDiv;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      divOut;
    logic              divLoad;
    logic              wrapOut;
    logic              busyOut;

    logic [NREQ-1:0]   reqB;
    logic [NREQ*W-1:0] reqDivB;
    logic [NREQ-1:0]   gntB;
    logic [W-1:0]      divOutB;
    logic              divLoadB;
    logic              wrapOutB;
    logic              busyOutB;

    int checks = 0;
    int errors = 0;

    clk_div_sched #(.NREQ(NREQ), .W(W), .RESET_DIV(32'd5)) dutA (
        .clk(clk), .rst_n(rst_n), .req(req), .req_div(reqDiv),
        .gnt(gnt), .div_n_out(divOut), .div_load(divLoad),
        .wrap(wrapOut), .busy(busyOut)
    );

    clk_div_sched #(.NREQ(NREQ), .W(W), .RESET_DIV(32'd0)) dutB (
        .clk(clk), .rst_n(rst_n), .req(reqB), .req_div(reqDivB),
        .gnt(gntB), .div_n_out(divOutB), .div_load(divLoadB),
        .wrap(wrapOutB), .busy(busyOutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of dutA. It tracks the position inside the current
    // period, the applied ratio, and at most one waiting request.
    int mPos, mRatio, mStart, mWho, mValue, mGrant, lastGrant, cand;
    bit mWaiting, mLoad, mBoundary;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPos = 0; mRatio = RESET_A; mStart = 0; mWho = 0; mValue = 0;
            mGrant = -1; mLoad = 0; mWaiting = 0;
        end else begin
            mBoundary = (mPos == mRatio);
            lastGrant = mGrant;
            mGrant = -1;
            mLoad  = 0;
            if (mWaiting && mBoundary) begin
                mRatio   = mValue;
                mPos     = 0;
                mGrant   = mWho;
                mLoad    = 1;
                mWaiting = 0;
            end else begin
                mPos = mBoundary ? 0 : mPos + 1;
                if (!mWaiting) begin
                    for (int k = 0; k < NREQ; k++) begin
                        cand = (mStart + k) % NREQ;
                        if (!mWaiting && req[cand] && cand != lastGrant) begin
                            mWaiting = 1;
                            mWho     = cand;
                            mValue   = int'(reqDiv[cand*W +: W]);
                            mStart   = (cand + 1) % NREQ;
                        end
                    end
                end
            end
        end
    end

    // Counts one comparison and reports it when the value is wrong.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compares every dutA output with the model.
    task automatic checkOutput();
        logic [31:0] expGnt;
        expGnt = (mGrant >= 0) ? (32'd1 << mGrant) : 32'd0;
        checkVal("model gnt", {28'd0, gnt}, expGnt);
        checkVal("model div_n_out", divOut, 32'(mRatio));
        checkVal("model div_load", {31'd0, divLoad}, {31'd0, mLoad});
        checkVal("model wrap", {31'd0, wrapOut}, {31'd0, (mPos == mRatio)});
        checkVal("model busy", {31'd0, busyOut}, {31'd0, mWaiting});
    endtask

    // Advances to the next falling edge and checks dutA against the model.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
    endtask

    // Resets both instances. Returns at a falling edge with rst_n released.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; reqDiv = '0; reqB = '0; reqDivB = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    // Runs cycles with requesters that drop req when granted, and counts
    // the grants seen for requester 2.
    int gnt2Seen;
    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus();
            if (gnt[2]) gnt2Seen++;
            if (mGrant >= 0) req[mGrant] = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0]  reqIn;
        logic [31:0] div1In;
        logic [3:0]  expGnt;
        logic        expLoad;
        logic [31:0] expDiv;
        logic        expWrap;
        logic        expBusy;
    } vec_t;

    vec_t        vecs [11];
    logic [3:0]  expGntB [10];

    initial begin
        // Request from requester 1 for ratio 3, asserted when cnt = 1.
        vecs[0]  = '{4'b0000, 32'd0, 4'b0000, 1'b0, 32'd5, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 32'd3, 4'b0000, 1'b0, 32'd5, 1'b0, 1'b1};
        vecs[2]  = '{4'b0010, 32'd3, 4'b0000, 1'b0, 32'd5, 1'b0, 1'b1};
        vecs[3]  = '{4'b0010, 32'd3, 4'b0000, 1'b0, 32'd5, 1'b0, 1'b1};
        vecs[4]  = '{4'b0010, 32'd3, 4'b0000, 1'b0, 32'd5, 1'b1, 1'b1};
        vecs[5]  = '{4'b0010, 32'd3, 4'b0010, 1'b1, 32'd3, 1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 32'd0, 4'b0000, 1'b0, 32'd3, 1'b0, 1'b0};
        vecs[7]  = '{4'b0000, 32'd0, 4'b0000, 1'b0, 32'd3, 1'b0, 1'b0};
        vecs[8]  = '{4'b0000, 32'd0, 4'b0000, 1'b0, 32'd3, 1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 32'd0, 4'b0000, 1'b0, 32'd3, 1'b0, 1'b0};
        vecs[10] = '{4'b0000, 32'd0, 4'b0000, 1'b0, 32'd3, 1'b0, 1'b0};

        expGntB[0] = 4'b0000; expGntB[1] = 4'b0000; expGntB[2] = 4'b0001;
        expGntB[3] = 4'b0000; expGntB[4] = 4'b0010; expGntB[5] = 4'b0000;
        expGntB[6] = 4'b0100; expGntB[7] = 4'b0000; expGntB[8] = 4'b1000;
        expGntB[9] = 4'b0000;

        rst_n = 1'b1;
        req = '0; reqDiv = '0; reqB = '0; reqDivB = '0;

        // Reset values, then the idle period of RESET_DIV + 1 cycles.
        doReset();
        for (int c = 0; c < 12; c++) begin
            checkVal("idle div_n_out", divOut, 32'd5);
            checkVal("idle wrap", {31'd0, wrapOut}, {31'd0, (c % 6 == 5)});
            checkVal("idle gnt", {28'd0, gnt}, 32'd0);
            checkVal("idle busy", {31'd0, busyOut}, 32'd0);
            applyStimulus();
        end

        // Vector table: a commit waits for the cnt = 5 boundary.
        doReset();
        for (int v = 0; v < 11; v++) begin
            req = vecs[v].reqIn;
            reqDiv[63:32] = vecs[v].div1In;
            applyStimulus();
            checkVal("vec gnt", {28'd0, gnt}, {28'd0, vecs[v].expGnt});
            checkVal("vec div_load", {31'd0, divLoad}, {31'd0, vecs[v].expLoad});
            checkVal("vec div_n_out", divOut, vecs[v].expDiv);
            checkVal("vec wrap", {31'd0, wrapOut}, {31'd0, vecs[v].expWrap});
            checkVal("vec busy", {31'd0, busyOut}, {31'd0, vecs[v].expBusy});
        end

        // Four simultaneous requests on dutB (continuous wrap). Expected
        // grant order is 0,1,2,3, two cycles apart.
        doReset();
        reqB = 4'b1111;
        reqDivB = {32'd6, 32'd0, 32'd0, 32'd0};
        for (int s = 1; s < 10; s++) begin
            @(negedge clk);
            checkVal("rr gnt order", {28'd0, gntB}, {28'd0, expGntB[s]});
            if (s == 1) checkVal("rr busy", {31'd0, busyOutB}, 32'd1);
            for (int j = 0; j < NREQ; j++) begin
                if (gntB[j]) begin
                    checkVal("rr div_n_out", divOutB, reqDivB[j*W +: W]);
                    checkVal("rr div_load", {31'd0, divLoadB}, 32'd1);
                    reqB[j] = 1'b0;
                end
            end
        end
        checkVal("rr final div", divOutB, 32'd6);

        // Requester 2 pulses while requester 3 is latched, so it is never
        // granted. When it asks again later, it is granted.
        doReset();
        gnt2Seen = 0;
        applyStimulus();
        req[3] = 1'b1; reqDiv[127:96] = 32'd2;
        applyStimulus();
        checkVal("withdraw busy", {31'd0, busyOut}, 32'd1);
        req[2] = 1'b1; reqDiv[95:64] = 32'd4;
        applyStimulus();
        req[2] = 1'b0;
        runCycles(12);
        checkVal("withdraw no gnt2", 32'(gnt2Seen), 32'd0);
        checkVal("withdraw div3", divOut, 32'd2);
        req[2] = 1'b1; reqDiv[95:64] = 32'd7;
        runCycles(10);
        checkVal("reassert gnt2 count", 32'(gnt2Seen), 32'd1);
        checkVal("reassert div", divOut, 32'd7);

        // Reset during PEND drops the latched ratio 9.
        doReset();
        req[0] = 1'b1; reqDiv[31:0] = 32'd20;
        runCycles(7);
        checkVal("setup div20", divOut, 32'd20);
        req[1] = 1'b1; reqDiv[63:32] = 32'd9;
        runCycles(3);
        checkVal("pend busy", {31'd0, busyOut}, 32'd1);
        rst_n = 1'b0;
        req = '0;
        #1;
        checkVal("async rst div", divOut, 32'd5);
        checkVal("async rst busy", {31'd0, busyOut}, 32'd0);
        checkVal("async rst gnt", {28'd0, gnt}, 32'd0);
        checkVal("async rst load", {31'd0, divLoad}, 32'd0);
        checkVal("async rst wrap", {31'd0, wrapOut}, 32'd0);
        applyStimulus();
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            applyStimulus();
            checkVal("post rst gnt", {28'd0, gnt}, 32'd0);
            checkVal("post rst load", {31'd0, divLoad}, 32'd0);
        end

        // A request equal to the current ratio (4 -> 4) still waits and reloads.
        doReset();
        req[0] = 1'b1; reqDiv[31:0] = 32'd4;
        runCycles(6);
        checkVal("eq setup div", divOut, 32'd4);
        applyStimulus();
        req[0] = 1'b1;
        for (int s = 8; s <= 10; s++) begin
            applyStimulus();
            checkVal("eq busy", {31'd0, busyOut}, 32'd1);
            checkVal("eq gnt quiet", {28'd0, gnt}, 32'd0);
        end
        applyStimulus();
        checkVal("eq gnt", {28'd0, gnt}, 32'd1);
        checkVal("eq load", {31'd0, divLoad}, 32'd1);
        checkVal("eq div", divOut, 32'd4);
        checkVal("eq cnt restart", {31'd0, wrapOut}, 32'd0);
        req[0] = 1'b0;
        for (int s = 12; s <= 15; s++) begin
            applyStimulus();
            checkVal("eq wrap spacing", {31'd0, wrapOut}, {31'd0, (s == 15)});
        end

        // Random traffic from rule-abiding requesters, checked by the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            for (int i = 0; i < NREQ; i++) begin
                if (mGrant == i) begin
                    req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    reqDiv[i*W +: W] = 32'($urandom_range(0, 6));
                    req[i] = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
